// File: rtl/clock_pkg.sv
// Shared definitions for the clock alert path.
// FSM states, source codes and pending-bit layout.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RING = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_ALARM = 2'd1;
  localparam logic [1:0] SRC_TIMER = 2'd2;
  localparam logic [1:0] SRC_CHIME = 2'd3;

  localparam int P_ALARM = 0;
  localparam int P_TIMER = 1;
  localparam int P_CHIME = 2;

  // One-hot pending bit owned by a source code.
  function automatic logic [2:0] src_mask(input logic [1:0] src);
    logic [2:0] m;
    m = 3'b000;
    case (src)
      SRC_ALARM: m = 3'b001;
      SRC_TIMER: m = 3'b010;
      SRC_CHIME: m = 3'b100;
      default:   m = 3'b000;
    endcase
    return m;
  endfunction

  // Fixed priority: alarm > timer > chime.
  function automatic logic [1:0] pick_src(input logic [2:0] pend);
    logic [1:0] s;
    s = SRC_NONE;
    if (pend[P_ALARM])      s = SRC_ALARM;
    else if (pend[P_TIMER]) s = SRC_TIMER;
    else if (pend[P_CHIME]) s = SRC_CHIME;
    return s;
  endfunction

endpackage

// File: rtl/alert_snooze_timer.sv
// Snooze re-trigger countdown for the alarm source.
// expire is high in the cycle the count holds 1.
module alert_snooze_timer
  import clock_pkg::*;
#(
  parameter int SNOOZE_CYC = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic cancel,
  output logic running,
  output logic expire
);

  localparam int W = $clog2(SNOOZE_CYC + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Cancel beats load; otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (cancel)
      cnt_d = '0;
    else if (load)
      cnt_d = W'(SNOOZE_CYC);
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // Countdown register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Status decoded from the register only.
  always_comb begin
    running = (cnt_q != '0);
    expire  = (cnt_q == W'(1));
  end

endmodule

// File: rtl/alert_scheduler.sv
// Arbitrates alarm/timer/chime onto one piezo pin.
// Latches requests, rings by priority, handles stop/snooze.
module alert_scheduler
  import clock_pkg::*;
#(
  parameter int ALARM_RING_CYC = 60,
  parameter int TIMER_RING_CYC = 10,
  parameter int CHIME_RING_CYC = 2,
  parameter int SNOOZE_CYC     = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarm_req,
  input  logic       timer_req,
  input  logic       chime_req,
  input  logic       chime_en,
  input  logic       ack_btn,
  input  logic       snooze_btn,
  output logic       buzzer,
  output logic [1:0] active_src,
  output logic [2:0] pending,
  output logic       snoozing,
  output logic [1:0] snooze_count
);

  localparam int MAX_AT  = (ALARM_RING_CYC > TIMER_RING_CYC)
                         ? ALARM_RING_CYC : TIMER_RING_CYC;
  localparam int MAX_DUR = (MAX_AT > CHIME_RING_CYC)
                         ? MAX_AT : CHIME_RING_CYC;
  localparam int RC_W    = $clog2(MAX_DUR);

  localparam logic [RC_W-1:0] A_LAST = RC_W'(ALARM_RING_CYC - 1);
  localparam logic [RC_W-1:0] T_LAST = RC_W'(TIMER_RING_CYC - 1);
  localparam logic [RC_W-1:0] C_LAST = RC_W'(CHIME_RING_CYC - 1);
  localparam logic [1:0]      MAX_SN = 2'(MAX_SNOOZE);

  state_t          state_q, state_d;
  logic [1:0]      src_q, src_d;
  logic [RC_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [2:0]      pend_q, pend_d;
  logic [1:0]      scnt_q, scnt_d;

  logic            sn_load, sn_cancel;
  logic            sn_running, sn_expire;
  logic [2:0]      req;
  logic [RC_W-1:0] last_cnt;
  logic            ringing, is_alarm;
  logic            do_ack, do_snooze;

  alert_snooze_timer #(
    .SNOOZE_CYC(SNOOZE_CYC)
  ) u_snooze (
    .clk    (clk),
    .reset  (reset),
    .load   (sn_load),
    .cancel (sn_cancel),
    .running(sn_running),
    .expire (sn_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_NONE;
      ring_cnt_q <= '0;
      pend_q     <= '0;
      scnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      ring_cnt_q <= ring_cnt_d;
      pend_q     <= pend_d;
      scnt_q     <= scnt_d;
    end
  end

  // Request latching, arbitration and next-state.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    ring_cnt_d = ring_cnt_q;
    scnt_d     = scnt_q;
    sn_load    = 1'b0;
    sn_cancel  = 1'b0;

    ringing  = (state_q == ST_RING);
    is_alarm = (src_q == SRC_ALARM);

    case (src_q)
      SRC_ALARM: last_cnt = A_LAST;
      SRC_TIMER: last_cnt = T_LAST;
      default:   last_cnt = C_LAST;
    endcase

    req = {chime_req & chime_en, timer_req, alarm_req | sn_expire};
    if (ringing)
      req = req & ~src_mask(src_q);
    pend_d = pend_q | req;

    if (alarm_req && sn_running && !(ringing && is_alarm))
      sn_cancel = 1'b1;

    do_ack    = ack_btn
              | (snooze_btn & is_alarm & (scnt_q >= MAX_SN));
    do_snooze = snooze_btn & is_alarm & (scnt_q < MAX_SN);

    unique case (state_q)
      ST_IDLE: begin
        if (ack_btn) begin
          sn_cancel = 1'b1;
          scnt_d    = 2'd0;
        end
        if (pend_d != 3'b000) begin
          state_d    = ST_RING;
          src_d      = pick_src(pend_d);
          ring_cnt_d = '0;
        end
      end
      ST_RING: begin
        if (do_ack) begin
          pend_d  = pend_d & ~src_mask(src_q);
          state_d = ST_GAP;
          if (is_alarm) begin
            scnt_d    = 2'd0;
            sn_cancel = 1'b1;
          end
        end else if (do_snooze) begin
          pend_d[P_ALARM] = 1'b0;
          scnt_d          = scnt_q + 2'd1;
          sn_load         = 1'b1;
          state_d         = ST_GAP;
        end else if (ring_cnt_q == last_cnt) begin
          pend_d  = pend_d & ~src_mask(src_q);
          state_d = ST_GAP;
          if (is_alarm)
            scnt_d = 2'd0;
        end else if (!is_alarm && pend_d[P_ALARM]) begin
          if (src_q == SRC_CHIME)
            pend_d[P_CHIME] = 1'b0;
          state_d = ST_GAP;
        end else begin
          ring_cnt_d = ring_cnt_q + RC_W'(1);
        end
      end
      ST_GAP: begin
        if (ack_btn) begin
          sn_cancel = 1'b1;
          scnt_d    = 2'd0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    buzzer       = 1'b0;
    active_src   = SRC_NONE;
    pending      = pend_q;
    snoozing     = sn_running;
    snooze_count = scnt_q;
    if (state_q == ST_RING) begin
      active_src = src_q;
      buzzer     = is_alarm ? ~ring_cnt_q[0] : 1'b1;
    end
  end

endmodule

// File: doc/alert_scheduler.md
# alert_scheduler

Shares the single piezo output between the three alert sources of the clock: alarm match, timer expiry and hourly chime. It sits between the clock core's buzzer pulses and the board buzzer pin. It latches requests and arbitrates them by fixed priority. It drives a per-source ring pattern for a bounded duration and handles stop/snooze buttons, including a snooze re-trigger timer.

## Interface
- `ALARM_RING_CYC`, default 60: alarm ring duration in clk cycles (≥2).
- `TIMER_RING_CYC`, default 10: timer ring duration in cycles (≥1).
- `CHIME_RING_CYC`, default 2: chime ring duration in cycles (≥1).
- `SNOOZE_CYC`, default 300: snooze delay in cycles (≥2).
- `MAX_SNOOZE`, default 3: maximum snoozes per alarm event (1..3).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `alarm_req`  in  1  one-cycle pulse from the alarm compare.
- `timer_req`  in  1  one-cycle pulse at timer expiry.
- `chime_req`  in  1  one-cycle pulse at the top of each hour.
- `chime_en`  in  1  level; when 0, `chime_req` is dropped.
- `ack_btn`  in  1  one-cycle pulse, debounced, stop.
- `snooze_btn`  in  1  one-cycle pulse, debounced.
- `buzzer`  out  1  piezo drive.
- `active_src`  out  2  0 none, 1 alarm, 2 timer, 3 chime. Nonzero only in RING.
- `pending`  out  3  {chime, timer, alarm} latched requests.
- `snoozing`  out  1  snooze timer running.
- `snooze_count`  out  2  snoozes used in the current alarm event.

## Operation
- **Request latching.** A request sets its `pending` bit; requests are idempotent while the bit is already set. A request for the source currently ringing is dropped.
- **Priority.** alarm > timer > chime.
- **FSM states.** IDLE, RING, GAP.
- **IDLE.**
  - If `pending` is nonzero, or a request arrives this cycle: go to RING with the highest-priority source, `ring_cnt` = 0.
  - `ack_btn` in IDLE or GAP cancels snooze: `snoozing` goes to 0 and `snooze_count` to 0.
- **RING.**
  - `ring_cnt` increments each cycle.
  - Buzzer pattern: alarm = `~ring_cnt[0]`; timer and chime = 1.
- **Timeout.** When `ring_cnt` reaches DUR−1, clear the source's `pending` bit and go to GAP. For an alarm, also clear `snooze_count`.
- **ack_btn in RING.** Clear the source's `pending` bit and go to GAP. For an alarm, also clear `snooze_count` and cancel any snooze.
- **snooze_btn in RING.**
  - Alarm source with `snooze_count` < MAX_SNOOZE: clear the alarm `pending` bit, increment `snooze_count`, load the snooze timer with SNOOZE_CYC, go to GAP.
  - Alarm source with `snooze_count` = MAX_SNOOZE: behaves exactly as `ack_btn`.
  - Any other source: ignored.
- **Simultaneous buttons.** `ack_btn` wins over `snooze_btn`.
- **Preemption.** An alarm becoming pending during a timer or chime ring causes GAP on the next cycle.
  - A preempted timer keeps its `pending` bit and later restarts at full duration.
  - A preempted chime has its `pending` bit cleared.
  - Nothing preempts an alarm. A timer does not preempt a chime.
- **GAP.** Lasts one cycle with `buzzer` = 0, then IDLE. Back-to-back rings are therefore separated by exactly 2 low cycles.
- **Snooze timer.**
  - Decrements every cycle while nonzero.
  - In the cycle it holds 1, the alarm `pending` bit is set.
  - A fresh `alarm_req` while snoozing sets `pending`, zeroes the timer, and keeps `snooze_count`.
- **Counter widths.** `$clog2` of the largest bound. No counter wraps, because every bound is checked before incrementing.

## Timing
- **Reset values.** `buzzer` = 0, `active_src` = 0, `pending` = 0, `snoozing` = 0, `snooze_count` = 0, state IDLE. All are cleared immediately on `reset` assertion, including mid-ring.
- **Registered outputs.** All outputs are decoded from registered state only; there is no input-to-output combinational path.
- **Start latency.** A request at cycle n in IDLE gives RING, `buzzer` and `active_src` valid at n+1.
- **Ring length.** Exactly DUR cycles.
- **Stop latency.** `ack_btn` or `snooze_btn` at cycle n gives `buzzer` = 0 at n+1.
- **Snooze re-ring.** Snooze at cycle n causes the alarm to ring again at n+SNOOZE_CYC+1 if idle. If another source is ringing, it preempts that ring.

## Structure
- Shared package `clock_pkg` holds:
  - the FSM state encoding (IDLE/RING/GAP);
  - the source codes SRC_NONE/ALARM/TIMER/CHIME;
  - the pending bit indices.
- One sub-module, `alert_snooze_timer`:
  - inputs: load, cancel;
  - outputs: running, expire pulse;
  - parameter: SNOOZE_CYC.
- All remaining logic lives in the top module: arbitration, FSM, ring counter and pattern decode.

## Test plan
All scenarios use ALARM=8, TIMER=4, CHIME=2, SNOOZE=10, MAX_SNOOZE=2.
1. **Alarm timeout.** `alarm_req` at cycle 5 → `buzzer` = 1,0,1,0,1,0,1,0 on cycles 6–13 with `active_src` = 1. `pending` = 0 and `buzzer` = 0 from cycle 14.
2. **Simultaneous requests.** `timer_req` and `chime_req` at cycle 3 → timer rings cycles 4–7, `buzzer` low at 8–9, chime rings 10–11, then `pending` = 0.
3. **Alarm preemption.** `timer_req` at 0, `alarm_req` at 2 → timer on 1–2, low 3–4, alarm rings 5–12. The timer then restarts and rings 4 cycles at 15–18.
4. **Snooze exhaustion.** Snooze at ring cycle 2 → `snoozing` = 1, `snooze_count` = 1, alarm re-rings 11 cycles later. A second snooze gives `snooze_count` = 2. A third `snooze_btn` acts as ack: `snooze_count` = 0 and no re-ring.
5. **Button and chime edge cases.**
   - `ack_btn` and `snooze_btn` in the same cycle during an alarm → stopped, `snoozing` = 0.
   - `chime_req` with `chime_en` = 0 → `pending[2]` stays 0.
   - `ack_btn` while snoozing in IDLE → snooze cancelled, no re-ring.
6. **Reset mid-ring.** Assert `reset` at alarm ring cycle 3 → all outputs 0 in the same cycle. Deassert, issue `timer_req` → a normal 4-cycle ring.
